gf_mult_seq: RTL

- Parametrised iterative GF(2^WIDTH) multiplier with an optional XOR-accumulate mode, replacing fixed-constant AES multipliers.
- Multiplies two arbitrary field elements, not just the constants 02/03/09/0B/0D/0E.
- Used by MixColumns/InvMixColumns datapaths and key-schedule helpers.
- Valid/ready handshake on input and output; one operation in flight.

---
 rtl/gf_mult_seq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/gf_mult_seq.sv
// Iterative GF(2^WIDTH) multiplier (MSB-first Horner) with optional XOR-accumulate.
// Valid/ready on both sides, one operation in flight.
module gf_mult_seq #(
  parameter int unsigned     WIDTH          = 8,
  parameter logic [WIDTH-1:0] POLY          = 8'h1B,
  parameter int unsigned     BITS_PER_CYCLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic             in_mac,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_product
);

  if (BITS_PER_CYCLE == 0 || WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("gf_mult_seq: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  localparam int unsigned ITER = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, acc_q, acc_d, prod_q, prod_d;
  logic [WIDTH-1:0] acc_step, b_step;
  logic             mac_q, mac_d, valid_q, valid_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], 1'b0} ^ (x[WIDTH-1] ? POLY : '0);
  endfunction

  always_comb begin
    // Consume BITS_PER_CYCLE multiplier bits, most significant first.
    acc_step = acc_q;
    b_step   = b_q;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      acc_step = xtime(acc_step) ^ (b_step[WIDTH-1] ? a_q : '0);
      b_step   = {b_step[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    mac_d   = mac_q;
    acc_d   = acc_q;
    count_d = count_q;
    prod_d  = prod_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          c_d     = in_c;
          mac_d   = in_mac;
          acc_d   = '0;
          count_d = CW'(ITER);
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d   = acc_step;
        b_d     = b_step;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          prod_d  = acc_step ^ (mac_q ? c_q : '0);
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      mac_q   <= 1'b0;
      acc_q   <= '0;
      count_q <= '0;
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      mac_q   <= mac_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      prod_q  <= prod_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = valid_q;
  assign out_product = prod_q;

endmodule
